// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the write-back register file and scoreboard.
// The optional same-cycle bypass is selected by defining REGFILE_BYPASS_EN.
package wb_regfile_pkg;

  localparam int NUM_REGS  = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W_DEF = 2;

  // One-hot select of a register; r0 never selects because it holds no state.
  function automatic logic [NUM_REGS-1:0] addr_decode(input logic en,
                                                      input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    if (en) sel[addr] = 1'b1;
    sel[0] = 1'b0;
    return sel;
  endfunction

endpackage

// File: rtl/wb_sb_cnt.sv
// One saturating pending-write counter: up on issue, down on write-back, clear on flush.
// ovf/unf pulse when an update is refused at a saturation bound.
module wb_sb_cnt
  import wb_regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             inc_only;
  logic             dec_only;
  logic             at_max;
  logic             at_zero;

  assign inc_only = inc && !dec;
  assign dec_only = dec && !inc;
  assign at_max   = (cnt_q == {CNT_W{1'b1}});
  assign at_zero  = (cnt_q == '0);

  // A clear overrides every update, so nothing is refused in a flush cycle.
  assign ovf = !clr && inc_only && at_max;
  assign unf = !clr && dec_only && at_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_only && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_only && !at_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file (r0 hard-wired to zero) with per-register pending-write
// scoreboard driving the decode stall. REGFILE_BYPASS_EN adds same-cycle write-back bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wbpr_wb_write_back_addr,
  input  logic [DATA_W-1:0] wbpr_wb_write_back_data,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  input  logic              id_issue_valid,
  input  logic [ADDR_W-1:0] id_issue_rd,
  input  logic              flush,
  output logic              id_stall,
  output logic              sb_err
);

  logic [DATA_W-1:0]               regs_q [NUM_REGS];
  logic                            we;
  logic [NUM_REGS-1:0]             wb_hit;
  logic [NUM_REGS-1:0]             iss_hit;
  logic [NUM_REGS-1:0][CNT_W-1:0]  cnt;
  logic [NUM_REGS-1:0]             ovf;
  logic [NUM_REGS-1:0]             unf;
  logic [NUM_REGS-1:0]             busy;
  logic                            sb_err_q;
  logic                            sb_err_d;

  assign we      = wb_valid && (wbpr_wb_write_back_addr != '0);
  assign wb_hit  = addr_decode(we, wbpr_wb_write_back_addr);
  assign iss_hit = addr_decode(id_issue_valid, id_issue_rd);

  // The write-back is older than anything being flushed, so it always commits.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else if (we) begin
      regs_q[wbpr_wb_write_back_addr] <= wbpr_wb_write_back_data;
    end
  end

  assign cnt[0] = '0;
  assign ovf[0] = 1'b0;
  assign unf[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    wb_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .inc     (iss_hit[g]),
      .dec     (wb_hit[g]),
      .clr     (flush),
      .cnt     (cnt[g]),
      .ovf     (ovf[g]),
      .unf     (unf[g])
    );
  end

  // A register is busy while writes are outstanding; with bypass the last one
  // landing this cycle already releases it.
  always_comb begin
    busy = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy[i] = (cnt[i] != '0);
`ifdef REGFILE_BYPASS_EN
      if (wb_hit[i] && (cnt[i] == CNT_W'(1))) busy[i] = 1'b0;
`endif
    end
  end

  assign id_stall = busy[id_rs1_addr] || busy[id_rs2_addr];

  always_comb begin
    id_rs1_data = '0;
    id_rs2_data = '0;
    if (id_rs1_addr != '0) id_rs1_data = regs_q[id_rs1_addr];
    if (id_rs2_addr != '0) id_rs2_data = regs_q[id_rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit[id_rs1_addr]) id_rs1_data = wbpr_wb_write_back_data;
    if (wb_hit[id_rs2_addr]) id_rs2_data = wbpr_wb_write_back_data;
`endif
  end

  assign sb_err_d = sb_err_q || (|ovf) || (|unf);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural register file and write-back scoreboard at the consumer end of the write-back stage. It accepts the write-back address and data leaving the MEM/WB pipeline register, commits them to 32 general registers, and serves two combinational read ports to decode. A per-register pending-write counter tracks in-flight destinations issued from decode and raises a decode stall until the matching write-back lands.

## Interface
Parameters:
- `RESET_VAL`, default 0: value loaded into every register r1–r31 on reset.
- `CNT_W`, default 2: pending-counter width; the maximum in-flight writes per register is 2^CNT_W−1.

Ports (`width` is the datapath-width macro from para.v):
- `sys_clk`  in  1  sole clock, rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `wb_valid`  in  1  write-back qualifier for the current cycle.
- `wbpr_wb_write_back_addr`  in  5  write-back destination register.
- `wbpr_wb_write_back_data`  in  `width`  write-back data.
- `id_rs1_addr`, `id_rs2_addr`  in  5  decode source registers.
- `id_rs1_data`, `id_rs2_data`  out  `width`  source operands, combinational.
- `id_issue_valid`  in  1  an instruction with a destination leaves decode this cycle.
- `id_issue_rd`  in  5  destination of the issuing instruction.
- `flush`  in  1  kills all younger in-flight instructions.
- `id_stall`  out  1  a source operand is pending.
- `sb_err`  out  1  sticky: counter overflow or underflow detected.

## Operation
- The write is `we = wb_valid && addr != 0`. When `we` is high, `regs[addr] <= data` at the rising edge. x0 is never stored and always reads 0.
- Reads: `rsN_data = (rsN==0) ? 0 : regs[rsN]`, plus bypass when configured (see Configuration).
- Scoreboard: one `CNT_W`-bit counter per register r1–r31. Issues and write-backs to r0 are ignored.
  - Issue only: counter +1.
  - Write-back only: counter −1.
  - Issue and write-back to the same register in the same cycle: counter unchanged.
  - Increment at maximum: the counter holds and `sb_err` is set.
  - Decrement at 0: the counter holds at 0 and `sb_err` is set.
- `flush` clears every counter at the next edge and takes priority over the issue and write-back counter updates. A write-back in the flush cycle still writes its data into the register array, because the write-back instruction is older and committed.
- `id_stall` is high when, for any nonzero rsN, `cnt[rsN] != 0` and the register is not released by the current write-back. It is combinational.
- `sb_err` clears only on reset.

## Timing
- Reset values (asynchronous, immediate):
  - r1–r31 = `RESET_VAL`.
  - All counters = 0.
  - `sb_err` = 0.
  - `id_stall` = 0.
  - Read outputs = `RESET_VAL` (0 for rs=0).
- Write latency: data is readable from the array the cycle after `we`. The same cycle is also possible with bypass.
- Counter updates are visible to `id_stall` the cycle after the edge.
- When reset asserts mid-operation, all pending state is discarded. After release, the first edge behaves as a fresh start.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When `we` is high and `wbpr_wb_write_back_addr == rsN != 0`, `rsN_data` is the write-back data in the same cycle.
  - A register with `cnt == 1` that is being written this cycle does not stall.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return only the array value.
  - Stall is evaluated on the counter alone, so a dependent instruction stalls one cycle longer.

## Structure
- Shared package/header (para.v): register count 32, register-address width 5, and the `CNT_W` default.
- Sub-module `wb_sb_cnt`: one saturating up/down counter with inc, dec, clr inputs and cnt, ovf, unf outputs. It is instantiated 31 times.

## Test plan
- Reset, then read r5 → `RESET_VAL`. Read r0 → 0. Check `id_stall` = 0 and `sb_err` = 0.
- Write back r0 with 0xFFFF → read r0 = 0, and no counter changes.
- Issue rd=3, then on the next cycle read rs1=3 → `id_stall` = 1. Write back r3 = 0x1234:
  - With `REGFILE_BYPASS_EN`: stall drops in the write-back cycle and `id_rs1_data` = 0x1234.
  - Without it: stall drops one cycle later and the data appears then.
- Issue rd=7 three times, then a fourth time → the counter holds at 3 and `sb_err` = 1. Write back r7 with no prior issue after reset → `sb_err` = 1.
- Issue rd=4 and write back rd=4 in the same cycle, with the counter at 1 beforehand → the counter stays at 1.
- With counters at r2=2 and r9=1, assert `flush` together with a write-back of r9 = 0x55 → all counters are 0 next cycle, `id_stall` = 0, and r9 reads 0x55.
